odometer_scan_host: RTL and testbench

Host-side scan controller for the odometer aging sensor, used on the tester FPGA and in the chip-level bench. It drives the configuration scan-in chain (SCANIN_DIN/SCANIN_CLK), pulses LOAD, and holds MEAS_TRIG high for a programmed window. It then clocks the counter readout chain (SCANOUT_CLK) and captures SCANOUT_DOUT into a parallel word. It is the other end of the odometer's scan-in and scan-out interfaces.

---
 rtl/odometer_scan_pkg.sv | 26 ++
 rtl/odometer_scan_host_if.sv | 19 +
 rtl/odometer_scan_clkgen.sv | 33 +++
 rtl/odometer_scan_host.sv | 181 ++++++++++++++++++
 tb/tb_odometer_scan_host.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/odometer_scan_pkg.sv
// Shared definitions for the odometer scan host.
//   state_t         : controller FSM states
//   *_DEF           : default chain lengths / timing
//   max_i()         : elaboration-time max helper for counter sizing
package odometer_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        LOAD_P,
        MEAS,
        GAP,
        SHIFT_OUT,
        FIN
    } state_t;

    localparam int CFG_W_DEF    = 16;
    localparam int OUT_W_DEF    = 32;
    localparam int DIV_DEF      = 4;
    localparam int MEAS_CYC_DEF = 1024;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/odometer_scan_host_if.sv
// Host-side handshake bundle for odometer_scan_host.
//   START_REQ/CFG_DATA          : request from the host (master)
//   BUSY/DONE/RD_DATA/CHK_ERR   : status and result from the controller (slave)
interface odometer_scan_host_if
    import odometer_scan_pkg::*;
#(
    parameter int CFG_W = CFG_W_DEF,
    parameter int OUT_W = OUT_W_DEF
);
    logic             START_REQ;
    logic [CFG_W-1:0] CFG_DATA;
    logic             BUSY;
    logic             DONE;
    logic [OUT_W-1:0] RD_DATA;
    logic             CHK_ERR;

    modport master (output START_REQ, CFG_DATA, input BUSY, DONE, RD_DATA, CHK_ERR);
    modport slave  (input START_REQ, CFG_DATA, output BUSY, DONE, RD_DATA, CHK_ERR);
endinterface

// File: rtl/odometer_scan_clkgen.sv
// Phase counter for the scan controller.
//   CLK, RESETB : clock, async active-low reset
//   restart     : reload phase to 0 on the next edge (slot end / state entry)
//   phase       : current phase count
//   slot_wrap   : last cycle of a 2*DIV bit slot (next cycle starts a new slot)
//   pre_rise    : last low cycle of a slot; data sampling point
//   sclk_nxt    : scan clock level for the next cycle (low first DIV, high last DIV)
module odometer_scan_clkgen #(
    parameter int DIV  = 4,
    parameter int PH_W = 11
) (
    input  logic            CLK,
    input  logic            RESETB,
    input  logic            restart,
    output logic [PH_W-1:0] phase,
    output logic            slot_wrap,
    output logic            pre_rise,
    output logic            sclk_nxt
);
    logic [PH_W-1:0] phase_nxt;

    assign phase_nxt = restart ? '0 : phase + PH_W'(1);

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) phase <= '0;
        else         phase <= phase_nxt;
    end

    assign pre_rise  = (phase == PH_W'(DIV - 1));
    assign slot_wrap = (phase == PH_W'(2 * DIV - 1));
    // The pins are registered by the caller, so it needs next cycle's level.
    assign sclk_nxt  = (phase_nxt >= PH_W'(DIV));
endmodule

// File: rtl/odometer_scan_host.sv
// Host-side scan controller for the odometer aging sensor.
// Sequence: scan CFG_DATA in (MSB first), pulse LOAD, hold MEAS_TRIG for
// MEAS_CYC cycles, settle, scan OUT_W bits out into RD_DATA, pulse DONE.
//   CLK, RESETB          : clock, async active-low reset
//   bus (slave)          : START_REQ/CFG_DATA in, BUSY/DONE/RD_DATA/CHK_ERR out
//   SCANIN_DIN/CLK, LOAD, MEAS_TRIG, SCANOUT_CLK : odometer control pins (registered)
//   SCANOUT_DOUT         : odometer readout chain data
//   SCANIN_DOUT          : scan-in chain tail, used only with SCANIN_CHECK_EN
// Optional feature macro: SCANIN_CHECK_EN (scan-in loopback check drives CHK_ERR).
module odometer_scan_host
    import odometer_scan_pkg::*;
#(
    parameter int CFG_W    = CFG_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int DIV      = DIV_DEF,
    parameter int MEAS_CYC = MEAS_CYC_DEF
) (
    input  logic CLK,
    input  logic RESETB,
    odometer_scan_host_if.slave bus,
    output logic SCANIN_DIN,
    output logic SCANIN_CLK,
    output logic LOAD,
    output logic MEAS_TRIG,
    output logic SCANOUT_CLK,
    input  logic SCANOUT_DOUT,
    input  logic SCANIN_DOUT
);
    localparam int BC_W = $clog2(max_i(CFG_W, OUT_W) + 1);
    localparam int PH_W = $clog2(max_i(2 * DIV, MEAS_CYC) + 1);
    localparam logic [BC_W-1:0] CFG_LAST  = BC_W'(CFG_W - 1);
    localparam logic [BC_W-1:0] OUT_LAST  = BC_W'(OUT_W - 1);
    localparam logic [PH_W-1:0] MEAS_LAST = PH_W'(MEAS_CYC - 1);

    state_t           state;
    logic [BC_W-1:0]  bit_cnt;
    logic [CFG_W-1:0] cfg_sr;
    logic [OUT_W-1:0] out_sr;
    logic [OUT_W-1:0] rd_data_q;
    logic             busy_q, done_q;
    logic [PH_W-1:0]  phase;
    logic             restart, slot_wrap, pre_rise, sclk_nxt;

    odometer_scan_clkgen #(.DIV(DIV), .PH_W(PH_W)) u_clkgen (
        .CLK      (CLK),
        .RESETB   (RESETB),
        .restart  (restart),
        .phase    (phase),
        .slot_wrap(slot_wrap),
        .pre_rise (pre_rise),
        .sclk_nxt (sclk_nxt)
    );

    // Phase restarts at every slot end and every state change, so each
    // state starts counting from 0 and the counter never wraps.
    always_comb begin
        restart = 1'b1;
        case (state)
            SHIFT_IN, LOAD_P, GAP, SHIFT_OUT: restart = slot_wrap;
            MEAS:                             restart = (phase == MEAS_LAST);
            default:                          restart = 1'b1;
        endcase
    end

`ifdef SCANIN_CHECK_EN
    // chk_sr holds the previous configuration word; the chain tail should
    // replay it MSB first while the new word is shifted in.
    logic [CFG_W-1:0] chk_sr;
    logic             chk_on, primed, chk_err_q;
    assign bus.CHK_ERR = chk_err_q;
`else
    logic unused_scanin_dout;
    assign unused_scanin_dout = SCANIN_DOUT;
    assign bus.CHK_ERR = 1'b0;
`endif

    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.RD_DATA = rd_data_q;

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            cfg_sr      <= '0;
            out_sr      <= '0;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            SCANIN_DIN  <= 1'b0;
            SCANIN_CLK  <= 1'b0;
            LOAD        <= 1'b0;
            MEAS_TRIG   <= 1'b0;
            SCANOUT_CLK <= 1'b0;
`ifdef SCANIN_CHECK_EN
            chk_sr      <= '0;
            chk_on      <= 1'b0;
            primed      <= 1'b0;
            chk_err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START_REQ) begin
                        state      <= SHIFT_IN;
                        bit_cnt    <= '0;
                        cfg_sr     <= bus.CFG_DATA;
                        SCANIN_DIN <= bus.CFG_DATA[CFG_W-1];
                        busy_q     <= 1'b1;
`ifdef SCANIN_CHECK_EN
                        chk_sr     <= cfg_sr;
                        chk_on     <= primed;
                        primed     <= 1'b1;
                        chk_err_q  <= 1'b0;
`endif
                    end
                end
                SHIFT_IN: begin
                    SCANIN_CLK <= sclk_nxt;
`ifdef SCANIN_CHECK_EN
                    if (pre_rise) begin
                        if (chk_on && (SCANIN_DOUT != chk_sr[CFG_W-1])) chk_err_q <= 1'b1;
                        chk_sr <= {chk_sr[CFG_W-2:0], 1'b0};
                    end
`endif
                    if (slot_wrap) begin
                        // Rotate so the word is intact again after CFG_W
                        // slots; it becomes the reference for the next run.
                        cfg_sr <= {cfg_sr[CFG_W-2:0], cfg_sr[CFG_W-1]};
                        if (bit_cnt == CFG_LAST) begin
                            state      <= LOAD_P;
                            LOAD       <= 1'b1;
                            SCANIN_DIN <= 1'b0;
                        end else begin
                            bit_cnt    <= bit_cnt + BC_W'(1);
                            SCANIN_DIN <= cfg_sr[CFG_W-2];
                        end
                    end
                end
                LOAD_P: begin
                    if (slot_wrap) begin
                        state     <= MEAS;
                        LOAD      <= 1'b0;
                        MEAS_TRIG <= 1'b1;
                    end
                end
                MEAS: begin
                    if (restart) begin
                        state     <= GAP;
                        MEAS_TRIG <= 1'b0;
                    end
                end
                GAP: begin
                    if (slot_wrap) begin
                        state   <= SHIFT_OUT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT_OUT: begin
                    SCANOUT_CLK <= sclk_nxt;
                    if (pre_rise) out_sr <= {out_sr[OUT_W-2:0], SCANOUT_DOUT};
                    if (slot_wrap) begin
                        if (bit_cnt == OUT_LAST) begin
                            state     <= FIN;
                            rd_data_q <= out_sr;
                            done_q    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                        end
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_odometer_scan_host.sv
// Directed bench for odometer_scan_host (CFG_W=8, OUT_W=8, DIV=2, MEAS_CYC=16)
// with a behavioural odometer: an 8-bit scan-in chain and a readout chain
// loaded with odo_val while LOAD is high.
module tb_odometer_scan_host;
    logic CLK, RESETB;
    logic SCANIN_DIN, SCANIN_CLK, LOAD, MEAS_TRIG, SCANOUT_CLK;
    logic SCANOUT_DOUT, SCANIN_DOUT;

    odometer_scan_host_if #(.CFG_W(8), .OUT_W(8)) bus ();

    odometer_scan_host #(.CFG_W(8), .OUT_W(8), .DIV(2), .MEAS_CYC(16)) dut (
        .CLK(CLK), .RESETB(RESETB), .bus(bus),
        .SCANIN_DIN(SCANIN_DIN), .SCANIN_CLK(SCANIN_CLK), .LOAD(LOAD),
        .MEAS_TRIG(MEAS_TRIG), .SCANOUT_CLK(SCANOUT_CLK),
        .SCANOUT_DOUT(SCANOUT_DOUT), .SCANIN_DOUT(SCANIN_DOUT)
    );

`ifdef SCANIN_CHECK_EN
    localparam logic CHK_EXP = 1'b1;
`else
    localparam logic CHK_EXP = 1'b0;
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors, checks;

    // odometer model and pin monitors
    logic [7:0] chain = 8'h00, out_chain = 8'h00, odo_val, din_cap;
    logic       si_q = 1'b0, so_q = 1'b0, mon_clr, flip_req;
    int         rise_cnt, so_cnt, load_cnt, meas_cnt, done_cnt;

    assign SCANIN_DOUT  = chain[7];
    assign SCANOUT_DOUT = out_chain[7];

    always @(posedge CLK) begin
        si_q <= SCANIN_CLK;
        so_q <= SCANOUT_CLK;
        if (SCANIN_CLK && !si_q) chain <= {chain[6:0], SCANIN_DIN};
        else if (flip_req)       chain <= chain ^ 8'h10;
        if (LOAD)                      out_chain <= odo_val;
        else if (SCANOUT_CLK && !so_q) out_chain <= {out_chain[6:0], 1'b0};
        if (mon_clr) begin
            rise_cnt <= 0; so_cnt <= 0; load_cnt <= 0; meas_cnt <= 0; done_cnt <= 0; din_cap <= 8'h00;
        end else begin
            if (SCANIN_CLK && !si_q) begin
                rise_cnt <= rise_cnt + 1;
                din_cap  <= {din_cap[6:0], SCANIN_DIN};
            end
            if (SCANOUT_CLK && !so_q) so_cnt <= so_cnt + 1;
            if (LOAD)     load_cnt <= load_cnt + 1;
            if (MEAS_TRIG) meas_cnt <= meas_cnt + 1;
            if (bus.DONE) done_cnt <= done_cnt + 1;
        end
    end

    // Starts a transaction and waits (bounded) for DONE. lat counts edges
    // from the edge after which START_REQ was raised; extra START_REQ
    // pulses are issued at lat==poke1/poke2 (0 = none).
    task automatic run_txn(input logic [7:0] cfg, input logic [7:0] odo, input int poke1,
                           input int poke2, output int lat, output logic busy1, output logic chk1);
        odo_val = odo;
        @(posedge CLK); #1; mon_clr = 1'b1;
        @(posedge CLK); #1; mon_clr = 1'b0;
        bus.START_REQ = 1'b1; bus.CFG_DATA = cfg;
        @(posedge CLK); #1;
        bus.START_REQ = 1'b0; bus.CFG_DATA = 8'hFF;
        lat = 1; busy1 = bus.BUSY; chk1 = bus.CHK_ERR;
        while (bus.DONE !== 1'b1 && lat < 300) begin
            @(posedge CLK); #1; lat++;
            bus.START_REQ = (lat == poke1 || lat == poke2);
        end
        bus.START_REQ = 1'b0;
    endtask

    task automatic test_reset();
        RESETB = 1'b1;
        #1 RESETB = 1'b0;
        #2;
        checks++; if ({bus.BUSY, bus.DONE, bus.CHK_ERR} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {bus.BUSY, bus.DONE, bus.CHK_ERR}); end
        checks++; if (bus.RD_DATA !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", bus.RD_DATA); end
        checks++; if ({SCANIN_DIN, SCANIN_CLK, LOAD, MEAS_TRIG, SCANOUT_CLK} !== 5'b0) begin errors++; $display("FAIL reset_pins: got %b want 00000", {SCANIN_DIN, SCANIN_CLK, LOAD, MEAS_TRIG, SCANOUT_CLK}); end
        repeat (2) @(posedge CLK);
        @(negedge CLK) RESETB = 1'b1;
    endtask

    task automatic test_basic();
        int lat; logic b1, c1;
        run_txn(8'hA5, 8'h3C, 0, 0, lat, b1, c1);
        checks++; if (lat !== 89) begin errors++; $display("FAIL basic_latency: got %0d want 89", lat); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b want 1", b1); end
        checks++; if (bus.RD_DATA !== 8'h3C) begin errors++; $display("FAIL basic_rd_data: got %h want 3c", bus.RD_DATA); end
        checks++; if (din_cap !== 8'hA5 || rise_cnt !== 8) begin errors++; $display("FAIL basic_scanin: got din %h rises %0d want a5/8", din_cap, rise_cnt); end
        checks++; if (load_cnt !== 4) begin errors++; $display("FAIL basic_load_len: got %0d want 4", load_cnt); end
        checks++; if (meas_cnt !== 16) begin errors++; $display("FAIL basic_meas_len: got %0d want 16", meas_cnt); end
        checks++; if (so_cnt !== 8) begin errors++; $display("FAIL basic_scanout_rises: got %0d want 8", so_cnt); end
        checks++; if (bus.CHK_ERR !== 1'b0) begin errors++; $display("FAIL basic_chk_err: got %b want 0", bus.CHK_ERR); end
        @(posedge CLK); #1;
        checks++; if ({bus.DONE, bus.BUSY} !== 2'b00) begin errors++; $display("FAIL basic_after_fin: got done/busy %b want 00", {bus.DONE, bus.BUSY}); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulse: got %0d cycles want 1", done_cnt); end
        checks++; if (chain !== 8'hA5) begin errors++; $display("FAIL basic_chain: got %h want a5", chain); end
    endtask

    task automatic test_busy_ignore();
        int lat; logic b1, c1;
        run_txn(8'h5A, 8'h81, 10, 50, lat, b1, c1);
        checks++; if (lat !== 89) begin errors++; $display("FAIL busy_latency: got %0d want 89", lat); end
        // START_REQ during the FIN cycle must also be ignored
        bus.START_REQ = 1'b1;
        @(posedge CLK); #1; bus.START_REQ = 1'b0;
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL busy_fin_start: got busy %b want 0", bus.BUSY); end
        repeat (100) @(posedge CLK);
        #1;
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", done_cnt); end
        checks++; if (bus.RD_DATA !== 8'h81) begin errors++; $display("FAIL busy_rd_data: got %h want 81", bus.RD_DATA); end
        checks++; if (chain !== 8'h5A) begin errors++; $display("FAIL busy_chain: got %h want 5a", chain); end
    endtask

    task automatic test_reset_mid();
        int n, lat; logic b1, c1;
        odo_val = 8'h77;
        @(posedge CLK); #1; bus.START_REQ = 1'b1; bus.CFG_DATA = 8'h99;
        @(posedge CLK); #1; bus.START_REQ = 1'b0;
        n = 0;
        while (MEAS_TRIG !== 1'b1 && n < 200) begin @(posedge CLK); #1; n++; end
        checks++; if (MEAS_TRIG !== 1'b1) begin errors++; $display("FAIL mid_meas_reached: got %b want 1", MEAS_TRIG); end
        repeat (2) @(posedge CLK);
        #3 RESETB = 1'b0;
        #1;
        checks++; if ({MEAS_TRIG, bus.BUSY, LOAD} !== 3'b000) begin errors++; $display("FAIL mid_reset_async: got trig/busy/load %b want 000", {MEAS_TRIG, bus.BUSY, LOAD}); end
        checks++; if (bus.RD_DATA !== 8'h00) begin errors++; $display("FAIL mid_reset_rd_data: got %h want 00", bus.RD_DATA); end
        @(negedge CLK) RESETB = 1'b1;
        run_txn(8'h3C, 8'hC3, 0, 0, lat, b1, c1);
        checks++; if (lat !== 89 || bus.RD_DATA !== 8'hC3) begin errors++; $display("FAIL mid_recover: got lat %0d data %h want 89/c3", lat, bus.RD_DATA); end
        checks++; if (bus.CHK_ERR !== 1'b0) begin errors++; $display("FAIL mid_first_chk: got %b want 0", bus.CHK_ERR); end
    endtask

    task automatic test_chk_loopback();
        int lat; logic b1, c1;
        run_txn(8'hA5, 8'h11, 0, 0, lat, b1, c1);
        checks++; if (bus.CHK_ERR !== 1'b0) begin errors++; $display("FAIL chk_clean_a5: got %b want 0", bus.CHK_ERR); end
        run_txn(8'h0F, 8'h22, 0, 0, lat, b1, c1);
        checks++; if (bus.CHK_ERR !== 1'b0) begin errors++; $display("FAIL chk_clean_0f: got %b want 0", bus.CHK_ERR); end
        @(posedge CLK); #1; flip_req = 1'b1;
        @(posedge CLK); #1; flip_req = 1'b0;
        run_txn(8'h33, 8'h44, 0, 0, lat, b1, c1);
        checks++; if (bus.CHK_ERR !== CHK_EXP) begin errors++; $display("FAIL chk_corrupt: got %b want %b", bus.CHK_ERR, CHK_EXP); end
        repeat (5) @(posedge CLK);
        #1;
        checks++; if (bus.CHK_ERR !== CHK_EXP) begin errors++; $display("FAIL chk_sticky: got %b want %b", bus.CHK_ERR, CHK_EXP); end
        run_txn(8'h44, 8'h55, 0, 0, lat, b1, c1);
        checks++; if (c1 !== 1'b0) begin errors++; $display("FAIL chk_clear_on_start: got %b want 0", c1); end
        checks++; if (bus.CHK_ERR !== 1'b0 || bus.RD_DATA !== 8'h55) begin errors++; $display("FAIL chk_after_clear: got err %b data %h want 0/55", bus.CHK_ERR, bus.RD_DATA); end
    endtask

    initial begin
        errors = 0; checks = 0;
        bus.START_REQ = 1'b0; bus.CFG_DATA = 8'h00;
        odo_val = 8'h00; mon_clr = 1'b0; flip_req = 1'b0;
        test_reset();
        test_basic();
        test_busy_ignore();
        test_reset_mid();
        test_chk_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
